// File: rtl/hazard_fwd_unit.sv
// Hazard/forwarding controller for the 5-stage pipeline: shadows EX/MEM/WB writers,
// drives stall/bubble/flush and ID operand forwarding. Define HAZ_FWD_EN to enable forwarding.
module hazard_fwd_unit #(
    parameter int REG_AW = 5,
    parameter int DW     = 32,
    parameter int CNT_W  = 16
) (
    input  logic              reloj,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_wr_en,
    input  logic [REG_AW-1:0] id_wr_dst,
    input  logic              id_is_load,
    input  logic              br_taken,
    input  logic [DW-1:0]     ex_result,
    input  logic [DW-1:0]     mem_result,
    input  logic [DW-1:0]     wb_result,
    input  logic [DW-1:0]     rf_a,
    input  logic [DW-1:0]     rf_b,
    output logic              stall,
    output logic              bubble,
    output logic              flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [DW-1:0]     op_a,
    output logic [DW-1:0]     op_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // Entry layout: {v, we, dst, ld}
    localparam int EW = REG_AW + 3;

    logic [EW-1:0]    ex_q, mem_q, wb_q;
    logic [EW-1:0]    ex_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             hazard;

    function automatic logic hits(input logic [EW-1:0] e,
                                  input logic [REG_AW-1:0] src,
                                  input logic used);
        hits = used && (src != '0) && e[EW-1] && e[EW-2] && (e[REG_AW:1] == src);
    endfunction

`ifdef HAZ_FWD_EN
    // A load sitting in EX shadows older writers: its data is not ready, so no
    // source is selected and the load-use stall covers the cycle.
    function automatic logic [1:0] pick(input logic [EW-1:0] ex_e,
                                        input logic [EW-1:0] mem_e,
                                        input logic [EW-1:0] wb_e,
                                        input logic [REG_AW-1:0] src,
                                        input logic used);
        pick = 2'd0;
        if (hits(ex_e, src, used))       pick = ex_e[0] ? 2'd0 : 2'd1;
        else if (hits(mem_e, src, used)) pick = 2'd2;
        else if (hits(wb_e, src, used))  pick = 2'd3;
    endfunction

    function automatic logic [DW-1:0] mux4(input logic [1:0] s, input logic [DW-1:0] rf,
                                           input logic [DW-1:0] ex, input logic [DW-1:0] mem,
                                           input logic [DW-1:0] wb);
        case (s)
            2'd1:    mux4 = ex;
            2'd2:    mux4 = mem;
            2'd3:    mux4 = wb;
            default: mux4 = rf;
        endcase
    endfunction

    always_comb begin
        fwd_a_sel = pick(ex_q, mem_q, wb_q, id_rs, id_rs_used);
        fwd_b_sel = pick(ex_q, mem_q, wb_q, id_rt, id_rt_used);
        op_a      = mux4(fwd_a_sel, rf_a, ex_result, mem_result, wb_result);
        op_b      = mux4(fwd_b_sel, rf_b, ex_result, mem_result, wb_result);
        hazard    = id_valid && ex_q[0] &&
                    (hits(ex_q, id_rs, id_rs_used) || hits(ex_q, id_rt, id_rt_used));
    end
`else
    // No bypass network: any in-flight writer of a source holds ID until it retires.
    logic unused_res;
    assign unused_res = ^{ex_result, mem_result, wb_result};

    always_comb begin
        fwd_a_sel = 2'd0;
        fwd_b_sel = 2'd0;
        op_a      = rf_a;
        op_b      = rf_b;
        hazard    = id_valid &&
                    (hits(ex_q,  id_rs, id_rs_used) || hits(ex_q,  id_rt, id_rt_used) ||
                     hits(mem_q, id_rs, id_rs_used) || hits(mem_q, id_rt, id_rt_used) ||
                     hits(wb_q,  id_rs, id_rs_used) || hits(wb_q,  id_rt, id_rt_used));
    end
`endif

    // A taken branch overrides the stall: the ID instruction is being discarded anyway.
    always_comb begin
        flush  = br_taken;
        stall  = hazard && !br_taken;
        bubble = hazard || br_taken;
        ex_d   = bubble ? '0 : {id_valid, id_wr_en, id_wr_dst, id_is_load};
    end

    always_ff @(posedge reloj) begin
        if (reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
            if (stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline (fetch, IF_ID, ID_EX, EX_MEM, MEM_WB).
- Keeps its own shadow copy of the destination and write information for the EX, MEM and WB stages.
- From that copy it produces operand-forward selects and data for the ID stage, load-use stalls, and the jump/branch flush.
- Sits alongside ruta_ctrl and drives the hold/bubble/flush inputs of fetch, IF_ID and ID_EX.

Parameters:
- REG_AW, 5: register address width; register 0 is hard-zero and is never forwarded or hazarded.
- DW, 32: datapath width of forwarded operands.
- CNT_W, 16: width of the saturating stall/flush event counters.

Ports:
- reloj in 1: clock, rising edge.
- reset in 1: synchronous, active-high.
- id_valid in 1: the IF_ID stage holds a real instruction.
- id_rs in REG_AW: source A address in ID.
- id_rt in REG_AW: source B address in ID.
- id_rs_used in 1: the ID instruction reads rs.
- id_rt_used in 1: the ID instruction reads rt.
- id_wr_en in 1: the ID instruction writes the register bank.
- id_wr_dst in REG_AW: final destination of the ID instruction (rt or rd, already selected).
- id_is_load in 1: the ID instruction is a load (MEM_RD).
- br_taken in 1: jump/branch resolved taken this cycle (SEL_DIR != sequential).
- ex_result in DW: combinational Y_ALU of the instruction in EX.
- mem_result in DW: EX_MEM ALU result (DIR).
- wb_result in DW: write-back mux output (DI_banco).
- rf_a in DW: bank output DOA.
- rf_b in DW: bank output DOB.
- stall out 1: hold PC and IF_ID this cycle.
- bubble out 1: load zero controls into ID_EX this cycle.
- flush out 1: clear IF_ID this cycle.
- fwd_a_sel out 2: source of operand A; 0 = bank, 1 = EX, 2 = MEM, 3 = WB.
- fwd_b_sel out 2: source of operand B, same encoding.
- op_a out DW: selected operand A.
- op_b out DW: selected operand B.
- stall_cnt out CNT_W: saturating count of stall cycles.
- flush_cnt out CNT_W: saturating count of flush cycles.

Behaviour:
- Shadow pipe: three registered entries, EX, MEM and WB. Each entry holds {v, we, dst, ld}.
- Every cycle the pipe shifts: WB <= MEM, MEM <= EX, EX <= ID entry.
- The ID entry is {id_valid, id_wr_en, id_wr_dst, id_is_load}.
- EX instead receives all-zero (a bubble) when bubble or flush is high.
- An entry counts as a writer only if v=1, we=1 and dst != 0.
- Forwarding for rs, and identically for rt:
  - if the source is unused or its address is 0 -> sel 0;
  - else the first matching writer in priority order EX, MEM, WB selects 1, 2 or 3;
  - else sel 0.
- op_a/op_b are the combinational mux of rf/ex/mem/wb per the selects.
- Load-use:
  - stall = bubble = 1 when the EX entry is a load writer and its dst matches a used, nonzero rs or rt of a valid ID instruction;
  - this lasts exactly 1 cycle; on the next cycle the load sits in MEM and mem_result forwarding applies;
  - a load in EX is never forwarded from ex_result; sel 1 applies only when ld=0.
- Flush:
  - br_taken=1 -> flush=1 and bubble=1 in the same cycle;
  - stall is forced to 0, so flush beats stall when both occur;
  - lasts 1 cycle unless br_taken is held.
- Counters:
  - stall_cnt +1 per cycle with stall=1;
  - flush_cnt +1 per cycle with flush=1;
  - both saturate at all-ones and never wrap.
- Reset, synchronous:
  - all shadow entries cleared;
  - stall, bubble and flush = 0;
  - fwd selects = 0;
  - both counters = 0.
  - Reset asserted mid-stall clears the pipe; the stall drops the cycle after the reset edge.
- Latency: all control outputs are combinational from the shadow registers and the current ID inputs. Zero-cycle decision, one register stage of state.

Optional Feature:
- Macro HAZ_FWD_EN.
- Defined: forwarding as above.
- Undefined:
  - fwd selects are tied to 0 and op_a/op_b = rf_a/rf_b;
  - stall = bubble = 1 whenever any writer in EX, MEM or WB matches a used nonzero ID source, not only loads;
  - flush precedence and the counters are unchanged.

Test Plan:
- ADD $3 then SUB $5,$3,$4 back-to-back -> cycle SUB in ID: fwd_a_sel=1, op_a=ex_result (0x0000_0007), stall=0.
- LW $2 then ADD $6,$2,$2:
  - first: stall=bubble=1 for 1 cycle, stall_cnt=1;
  - next cycle: fwd_a_sel=fwd_b_sel=2, op_a=mem_result.
- Writer to $0 followed by a reader of $0 -> fwd_a_sel=0, stall=0.
- br_taken=1 on the same cycle as a load-use condition -> flush=1, bubble=1, stall=0, flush_cnt=1; the EX entry is a bubble next cycle.
- Force 2^CNT_W+3 stall cycles (CNT_W=4 build) -> stall_cnt holds at 0xF.
- HAZ_FWD_EN undefined, ADD $3 then OR $7,$3,$1 -> stall=1 for 3 cycles (EX, MEM, WB matches), then fwd_a_sel=0, op_a=rf_a.
